// File: rtl/apb_master_global_pkg.sv
// Shared types and constants for the APB master bridge and its helpers.
package apb_master_global_pkg;

  // APB transfer phases as seen by the bridge FSM
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_fsm_state_e;

  // Transfer direction, matching the PWRITE encoding
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  // PPROT encoding: {instruction, non-secure, privileged}
  typedef enum logic [2:0] {
    NORMAL_SECURE_DATA              = 3'b000,
    PRIVILEGED_SECURE_DATA          = 3'b001,
    NORMAL_NONSECURE_DATA           = 3'b010,
    PRIVILEGED_NONSECURE_DATA       = 3'b011,
    NORMAL_SECURE_INSTRUCTION       = 3'b100,
    PRIVILEGED_SECURE_INSTRUCTION   = 3'b101,
    NORMAL_NONSECURE_INSTRUCTION    = 3'b110,
    PRIVILEGED_NONSECURE_INSTRUCTION = 3'b111
  } protection_type_e;

  // Default number of ACCESS cycles tolerated before a transfer is aborted
  localparam int APB_TIMEOUT_CYCLES = 16;

  // Response record at the widest supported data width and default counter width
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
    logic [7:0]  wait_states;
  } apb_bridge_rsp_s;

endpackage

// File: rtl/apb_master_slave_decoder.sv
// Address decoder: the top address bits pick one of NO_OF_SLAVES slaves.
module apb_master_slave_decoder #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int NO_OF_SLAVES  = 4,
  localparam int SLV_IDX_WIDTH = $clog2(NO_OF_SLAVES)
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic [SLV_IDX_WIDTH-1:0] slave_index,
  output logic [NO_OF_SLAVES-1:0]  slave_sel
);

  // Low address bits only matter to the slave itself
  logic [ADDRESS_WIDTH-SLV_IDX_WIDTH-1:0] unused_addr_s;
  assign unused_addr_s = addr[ADDRESS_WIDTH-SLV_IDX_WIDTH-1:0];

  // Slice the index from the MSBs and expand it to a one-hot select
  always_comb begin
    slave_index = addr[ADDRESS_WIDTH-1 -: SLV_IDX_WIDTH];
    slave_sel   = {NO_OF_SLAVES{1'b0}};
    slave_sel[slave_index] = 1'b1;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: one command at a time from a valid/ready port is run
// as an APB transfer on the decoded slave, and its outcome (read data,
// PSLVERR, timeout, wait-state count) is returned on a valid/ready response.
module apb_master_bridge
  import apb_master_global_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int NO_OF_SLAVES   = 4,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic                               pclk,
  input  logic                               preset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]           cmd_addr,
  input  logic [DATA_WIDTH-1:0]              cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]            cmd_strb,
  input  logic [2:0]                         cmd_prot,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_error,
  output logic                               rsp_timeout,
  output logic [WAIT_CNT_WIDTH-1:0]          rsp_wait_states,
  output logic [NO_OF_SLAVES-1:0]            pselx,
  output logic                               penable,
  output logic                               pwrite,
  output logic [ADDRESS_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]              pwdata,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  output logic [2:0]                         pprot,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NO_OF_SLAVES-1:0]            pready,
  input  logic [NO_OF_SLAVES-1:0]            pslverr
);

  localparam int SLV_IDX_WIDTH = $clog2(NO_OF_SLAVES);
  localparam int ACC_CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam int STRB_WIDTH    = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  localparam logic [ACC_CNT_WIDTH-1:0]  ACC_CNT_LAST = ACC_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ACC_CNT_WIDTH-1:0]  ACC_CNT_ZERO = {ACC_CNT_WIDTH{1'b0}};
  localparam logic [ACC_CNT_WIDTH-1:0]  ACC_CNT_ONE  = ACC_CNT_WIDTH'(1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ZERO    = {WAIT_CNT_WIDTH{1'b0}};
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE     = WAIT_CNT_WIDTH'(1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX     = {WAIT_CNT_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0]     DATA_ZERO    = {DATA_WIDTH{1'b0}};
  localparam logic [STRB_WIDTH-1:0]     STRB_ZERO    = {STRB_WIDTH{1'b0}};
  localparam logic [NO_OF_SLAVES-1:0]   SEL_ZERO     = {NO_OF_SLAVES{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0]  ADDR_ZERO    = {ADDRESS_WIDTH{1'b0}};

  logic [1:0]                state_r;
  logic [SLV_IDX_WIDTH-1:0]  slv_idx_r;
  logic [ACC_CNT_WIDTH-1:0]  acc_cnt_r;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_r;

  logic [SLV_IDX_WIDTH-1:0]  dec_idx_s;
  logic [NO_OF_SLAVES-1:0]   dec_sel_s;
  logic                      sel_ready_s;
  logic                      sel_err_s;
  logic [DATA_WIDTH-1:0]     sel_rdata_s;
  logic [WAIT_CNT_WIDTH-1:0] wait_inc_s;

  apb_master_slave_decoder #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NO_OF_SLAVES  (NO_OF_SLAVES)
  ) u_decoder (
    .addr        (cmd_addr),
    .slave_index (dec_idx_s),
    .slave_sel   (dec_sel_s)
  );

  // Only the addressed slave's handshake and data are ever looked at
  always_comb begin
    sel_ready_s = pready[slv_idx_r];
    sel_err_s   = pslverr[slv_idx_r];
    sel_rdata_s = prdata[slv_idx_r*DATA_WIDTH +: DATA_WIDTH];
  end

  // Wait-state counter increment that sticks at all-ones instead of wrapping
  always_comb begin
    if (wait_cnt_r == WAIT_MAX) begin
      wait_inc_s = wait_cnt_r;
    end else begin
      wait_inc_s = wait_cnt_r + WAIT_ONE;
    end
  end

  // Transfer FSM; every port output is a register updated here.
  // The response registers are loaded when ACCESS ends, and rsp_valid follows
  // one cycle later so the response fields are settled before they are offered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r         <= ST_IDLE;
      slv_idx_r       <= {SLV_IDX_WIDTH{1'b0}};
      acc_cnt_r       <= ACC_CNT_ZERO;
      wait_cnt_r      <= WAIT_ZERO;
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= DATA_ZERO;
      rsp_error       <= 1'b0;
      rsp_timeout     <= 1'b0;
      rsp_wait_states <= WAIT_ZERO;
      pselx           <= SEL_ZERO;
      penable         <= 1'b0;
      pwrite          <= 1'b0;
      paddr           <= ADDR_ZERO;
      pwdata          <= DATA_ZERO;
      pstrb           <= STRB_ZERO;
      pprot           <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr      <= cmd_addr;
            pwrite     <= cmd_write;
            pwdata     <= cmd_wdata;
            pstrb      <= cmd_write ? cmd_strb : STRB_ZERO;
            pprot      <= cmd_prot;
            pselx      <= dec_sel_s;
            penable    <= 1'b0;
            slv_idx_r  <= dec_idx_s;
            acc_cnt_r  <= ACC_CNT_ZERO;
            wait_cnt_r <= WAIT_ZERO;
            cmd_ready  <= 1'b0;
            state_r    <= ST_SETUP;
          end else begin
            cmd_ready  <= 1'b1;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state_r <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready_s) begin
            pselx           <= SEL_ZERO;
            penable         <= 1'b0;
            rsp_rdata       <= pwrite ? DATA_ZERO : sel_rdata_s;
            rsp_error       <= sel_err_s;
            rsp_timeout     <= 1'b0;
            rsp_wait_states <= wait_cnt_r;
            state_r         <= ST_RESP;
          end else if (acc_cnt_r == ACC_CNT_LAST) begin
            pselx           <= SEL_ZERO;
            penable         <= 1'b0;
            rsp_rdata       <= DATA_ZERO;
            rsp_error       <= 1'b1;
            rsp_timeout     <= 1'b1;
            rsp_wait_states <= wait_inc_s;
            state_r         <= ST_RESP;
          end else begin
            acc_cnt_r  <= acc_cnt_r + ACC_CNT_ONE;
            wait_cnt_r <= wait_inc_s;
          end
        end
        ST_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid       <= 1'b0;
            rsp_rdata       <= DATA_ZERO;
            rsp_error       <= 1'b0;
            rsp_timeout     <= 1'b0;
            rsp_wait_states <= WAIT_ZERO;
            cmd_ready       <= 1'b1;
            state_r         <= ST_IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          pselx     <= SEL_ZERO;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a per-slave model answers APB
// transfers, expected responses are queued at command issue and checked
// when the bridge offers them.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [7:0]  rsp_wait_states;
  logic [3:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [127:0] prdata;
  logic [3:0]  pready;
  logic [3:0]  pslverr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model configuration
  logic        cfg_hang = 1'b0;
  logic        cfg_err  = 1'b0;
  int          cfg_wait = 0;
  int          tb_acc   = 0;
  logic [31:0] slv_rdata [4];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    logic [7:0]  ws;
    int          lat;
    int          acc_cyc;
  } exp_t;
  exp_t exp_q[$];

  apb_master_bridge dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_wait_states(rsp_wait_states),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // cycle counter and ACCESS-cycle counter for the slave model
  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (penable) tb_acc <= tb_acc + 1;
    else         tb_acc <= 0;
  end

  // unselected slaves shout ready/error to prove they are ignored
  for (genvar g = 0; g < 4; g++) begin : g_slv
    assign pready[g]  = (pselx[g] && penable) ? (!cfg_hang && (tb_acc >= cfg_wait)) : 1'b1;
    assign pslverr[g] = pselx[g] ? (cfg_err && penable && pready[g]) : 1'b1;
    assign prdata[g*32 +: 32] = slv_rdata[g];
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] exp_sel,
                          input logic push, input exp_t exp);
    int n = 0;
    logic [3:0] exp_strb;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot;
    tick();
    cmd_valid = 1'b0;
    exp.acc_cyc = cyc;
    if (push) exp_q.push_back(exp);
    exp_strb = wr ? strb : 4'h0;
    checks++;
    if (pselx !== exp_sel || penable !== 1'b0 || paddr !== addr || pwrite !== wr ||
        pwdata !== wdata || pstrb !== exp_strb || pprot !== prot || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL setup_phase: got sel=%b en=%b addr=%h wr=%b wd=%h strb=%h prot=%h rdy=%b want sel=%b en=0 addr=%h wr=%b wd=%h strb=%h prot=%h rdy=0",
               pselx, penable, paddr, pwrite, pwdata, pstrb, pprot, cmd_ready,
               exp_sel, addr, wr, wdata, exp_strb, prot);
    end
    tick();
    checks++;
    if (pselx !== exp_sel || penable !== 1'b1 || paddr !== addr) begin
      errors++;
      $display("FAIL access_phase: got sel=%b en=%b addr=%h want sel=%b en=1 addr=%h",
               pselx, penable, paddr, exp_sel, addr);
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    exp_t e;
    while (rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_wait: got rsp_valid=%b want 1", rsp_valid);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL rsp_unexpected: got response, want none queued");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if ((cyc - e.acc_cyc) != e.lat) begin
      errors++; $display("FAIL rsp_latency: got %0d want %0d", cyc - e.acc_cyc, e.lat);
    end
    checks++;
    if (rsp_rdata !== e.rdata || rsp_error !== e.err || rsp_timeout !== e.tmo || rsp_wait_states !== e.ws) begin
      errors++;
      $display("FAIL rsp_fields: got rdata=%h err=%b tmo=%b ws=%0d want rdata=%h err=%b tmo=%b ws=%0d",
               rsp_rdata, rsp_error, rsp_timeout, rsp_wait_states, e.rdata, e.err, e.tmo, e.ws);
    end
    checks++;
    if (pselx !== 4'b0000 || penable !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rsp_apb_idle: got sel=%b en=%b rdy=%b want 0000 0 0", pselx, penable, cmd_ready);
    end
    if (rsp_ready === 1'b1) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL rsp_handshake: got valid=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
      end
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic er, input logic tm,
                              input logic [7:0] ws, input int lat);
    exp_t e;
    e.rdata = rd; e.err = er; e.tmo = tm; e.ws = ws; e.lat = lat; e.acc_cyc = 0;
    return e;
  endfunction

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) tick();
    preset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || pselx !== 4'h0 || penable !== 1'b0 || pwrite !== 1'b0 ||
        paddr !== 12'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0) begin
      errors++;
      $display("FAIL reset_apb: got rdy=%b sel=%b en=%b wr=%b addr=%h wd=%h strb=%h prot=%h want 1 0 0 0 0 0 0 0",
               cmd_ready, pselx, penable, pwrite, paddr, pwdata, pstrb, pprot);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 ||
        rsp_timeout !== 1'b0 || rsp_wait_states !== 8'h0) begin
      errors++; $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b tmo=%b ws=%0d want all 0",
                         rsp_valid, rsp_rdata, rsp_error, rsp_timeout, rsp_wait_states);
    end
  endtask

  task automatic test_write_zero_wait();
    cfg_wait = 0; cfg_err = 1'b0; cfg_hang = 1'b0;
    send_cmd(1'b1, 12'h404, 32'hDEADBEEF, 4'hF, 3'b010, 4'b0010, 1'b1, mk(32'h0, 1'b0, 1'b0, 8'd0, 3));
    wait_rsp();
  endtask

  task automatic test_read_wait();
    cfg_wait = 3; cfg_err = 1'b0; cfg_hang = 1'b0;
    send_cmd(1'b0, 12'hC10, 32'h0000_1111, 4'hF, 3'b001, 4'b1000, 1'b1, mk(32'h12345678, 1'b0, 1'b0, 8'd3, 6));
    wait_rsp();
  endtask

  task automatic test_slverr();
    cfg_wait = 1; cfg_err = 1'b1; cfg_hang = 1'b0;
    send_cmd(1'b0, 12'h820, 32'h0, 4'h3, 3'b000, 4'b0100, 1'b1, mk(32'hCAFE0002, 1'b1, 1'b0, 8'd1, 4));
    wait_rsp();
    cfg_err = 1'b0;
  endtask

  task automatic test_timeout();
    cfg_wait = 0; cfg_err = 1'b0; cfg_hang = 1'b1;
    send_cmd(1'b0, 12'h010, 32'h0, 4'hF, 3'b100, 4'b0001, 1'b1, mk(32'h0, 1'b1, 1'b1, 8'd16, 18));
    wait_rsp();
    cfg_hang = 1'b0;
  endtask

  task automatic test_back_to_back();
    cfg_wait = 0; cfg_err = 1'b0; cfg_hang = 1'b0;
    rsp_ready = 1'b0;
    send_cmd(1'b1, 12'h408, 32'h0BAD_F00D, 4'h5, 3'b000, 4'b0010, 1'b1, mk(32'h0, 1'b0, 1'b0, 8'd0, 3));
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || rsp_wait_states !== 8'd0 ||
          cmd_ready !== 1'b0 || pselx !== 4'h0 || penable !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: got valid=%b rdata=%h err=%b ws=%0d rdy=%b sel=%b en=%b want 1 0 0 0 0 0000 0",
                 rsp_valid, rsp_rdata, rsp_error, rsp_wait_states, cmd_ready, pselx, penable);
      end
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_release: got valid=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
    send_cmd(1'b0, 12'h004, 32'h0, 4'hF, 3'b000, 4'b0001, 1'b1, mk(32'hA5A5_0000, 1'b0, 1'b0, 8'd0, 3));
    wait_rsp();
    send_cmd(1'b1, 12'h87C, 32'h1357_9BDF, 4'hA, 3'b011, 4'b0100, 1'b1, mk(32'h0, 1'b0, 1'b0, 8'd0, 3));
    wait_rsp();
    send_cmd(1'b0, 12'hFFC, 32'h0, 4'h0, 3'b111, 4'b1000, 1'b1, mk(32'h12345678, 1'b0, 1'b0, 8'd0, 3));
    wait_rsp();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    cfg_hang = 1'b1;
    send_cmd(1'b0, 12'h400, 32'h0, 4'hF, 3'b000, 4'b0010, 1'b0, mk(32'h0, 1'b0, 1'b0, 8'd0, 0));
    tick();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    cfg_hang = 1'b0;
    checks++;
    if (pselx !== 4'h0 || penable !== 1'b0 || paddr !== 12'h0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got sel=%b en=%b addr=%h valid=%b rdy=%b want 0000 0 000 0 1",
                         pselx, penable, paddr, rsp_valid, cmd_ready);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid_no_rsp: got %0d valid cycles want 0", seen);
    end
    send_cmd(1'b1, 12'h7F0, 32'h2468_ACE0, 4'hC, 3'b010, 4'b0010, 1'b1, mk(32'h0, 1'b0, 1'b0, 8'd0, 3));
    wait_rsp();
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0;
    cmd_wdata = 32'h0; cmd_strb = 4'h0; cmd_prot = 3'h0; rsp_ready = 1'b1;
    slv_rdata[0] = 32'hA5A5_0000;
    slv_rdata[1] = 32'h5A5A_0001;
    slv_rdata[2] = 32'hCAFE_0002;
    slv_rdata[3] = 32'h1234_5678;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
